ncl4_inject_arbiter: RTL and testbench
======================================

# ncl4_inject_arbiter

Clocked round-robin arbiter and wavefront sequencer that shares the head of a 4-rail, one-hot NCL pipeline between NREQ synchronous requesters. It owns the pipeline's input rails and drives alternating DATA and NULL wavefronts. It advances only on the first stage's completion signal, after synchronizing it into the clock domain. It sits between clocked producer logic and the clockless pipeline head, replacing the free-running THnotN input generator.

## Interface
- NREQ, 4: number of requesters, 2..16
- SYNC_STAGES, 2: flops in the completion synchronizer, ≥2
- TIMEOUT, 255: cycles spent in one phase before err is set, 1..65535

- clk  in  1  sole clock
- init_n  in  1  asynchronous active-low reset; must be asserted together with pipeline init
- req  in  NREQ  per-requester request level; held until its gnt
- req_val  in  2*NREQ  per-requester 2-bit rail index; bits [2i+1:2i] belong to requester i
- comp_in  in  1  completion from first pipeline stage (TH14 of its rails): 1 = holds DATA, 0 = holds NULL; asynchronous
- rails  out  4  pipeline head rails, registered; 0000 = NULL, one-hot = DATA
- gnt  out  NREQ  one-cycle pulse to the requester whose DATA was accepted
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky phase-timeout flag
- err_clr  in  1  synchronous clear of err
- tok_cnt  out  16  completed DATA+NULL cycles, wraps at 65535→0

## Operation
- comp_in passes through SYNC_STAGES flops to give comp_s; the FSM uses only comp_s.
- IDLE: rails=0000. If any req bit is set and comp_s==0, pick the winner, latch its index and req_val, go to DATA.
- DATA: rails=onehot(latched val), meaning bit val is set. When comp_s==1, go to NULL and pulse gnt[idx] for one cycle.
- NULL: rails=0000. When comp_s==0, increment tok_cnt and go to IDLE.
- Round-robin: pointer ptr holds the last granted index, reset value NREQ-1. Search starts at ptr+1 mod NREQ and the first set req bit wins. ptr is updated to the winner when it is latched in IDLE.
- rails change only on FSM transitions. There is never a direct one-hot to one-hot change; every DATA is separated by 0000.
- The latched value is immune to later changes. Dropping req or changing req_val after latch does not affect rails, and gnt is still issued.
- req_val is sampled only on the latching cycle.
- Timeout: a phase counter clears on each state entry and increments in DATA and NULL. When it reaches TIMEOUT, err=1 (sticky). The FSM keeps waiting; a wavefront is never aborted.
- If err_clr and a new timeout occur in the same cycle, the timeout wins and err stays 1.
- If comp_s==1 in IDLE (stale DATA in pipeline), the FSM stays in IDLE and does not grant.

## Timing
- Reset (init_n=0, asynchronous): state=IDLE, rails=0000, gnt=0, busy=0, err=0, tok_cnt=0, ptr=NREQ-1, synchronizer flops=0.
- Reset mid-operation forces rails=0000 immediately. Pipeline contents are recovered only by the simultaneous pipeline init.
- req sampled high in IDLE at edge t gives rails one-hot and busy=1 from edge t (registered outputs update at t).
- comp_in rising at cycle c gives comp_s=1 after SYNC_STAGES edges. On the next edge, rails=0000 and gnt pulses, both in the same cycle.
- comp_in falling gives the NULL→IDLE transition SYNC_STAGES+1 edges later. tok_cnt updates on that edge.
- Back-to-back service: the next DATA can launch on the edge after IDLE is entered.
- Minimum period per token: 2*(SYNC_STAGES+1)+1 cycles.
- gnt is exactly one cycle wide, and no more than one gnt bit is high at once.

## Test plan
- Single requester: req[0]=1, req_val[1:0]=2, with a behavioural pipeline stage that echoes completion after 3 ns. Required: rails=0100, then 0000; gnt[0] pulses once; tok_cnt=1; no one-hot→one-hot edge.
- Round-robin: req=1111 held, each requester with a distinct val, 8 tokens. Required: grant order 0,1,2,3,0,1,2,3; each rails value matches its grantee's val; tok_cnt=8.
- Stuck completion: comp_in held 0 with TIMEOUT=10. Required: err=1 after 10 cycles in DATA and rails stay one-hot. Then err_clr pulse clears err; then raise comp_in and the sequence completes normally.
- Stale DATA: comp_in=1 at reset release with req[1]=1. Required: rails stay 0000, no gnt until comp_in falls, then normal service.
- Reset mid-DATA: assert init_n=0 while rails=0001. Required: rails=0000, gnt=0, err=0, tok_cnt=0 asynchronously; after release, requester 0 has first priority.
- Requester drops req and changes req_val one cycle after latch. Required: rails keep the latched value and gnt is still issued to that requester.

Source files
------------

// File: rtl/ncl4_inject_arbiter.sv
// Round-robin injector for the head of a 4-rail one-hot NCL pipeline.
// The arbiter grants one requester at a time and drives alternating DATA and NULL wavefronts, paced by the synchronized stage completion.
module ncl4_inject_arbiter #(
    parameter int NREQ        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] req_val,
    input  logic              comp_in,
    output logic [3:0]        rails,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              err,
    input  logic              err_clr,
    output logic [15:0]       tok_cnt
);

    localparam int          IW       = $clog2(NREQ);
    localparam logic [15:0] TMAX     = 16'(TIMEOUT);
    localparam logic [15:0] TPRE     = 16'(TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_NULL} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   comp_s;
    logic                   sync_ready;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [3:0]             rails_q, rails_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [15:0]            tok_q, tok_d;
    logic [15:0]            phase_q, phase_d;
    logic                   timeout_hit;
    logic                   win_found;
    logic [IW-1:0]          win_idx;
    logic [IW-1:0]          sel;
    logic [1:0]             win_val;
    int                     k;

    assign comp_s     = sync_q[SYNC_STAGES-1];
    // After reset the synchronizer holds zeros, not the real comp_in; no grant until it has refilled.
    assign sync_ready = prime_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            sync_q  <= '0;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], comp_in};
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sel       = '0;
        k         = 0;
        for (int i = 1; i <= NREQ; i++) begin
            k   = (int'(ptr_q) + i) % NREQ;
            sel = IW'(k);
            if (!win_found && req[sel]) begin
                win_found = 1'b1;
                win_idx   = sel;
            end
        end
        win_val = req_val[{win_idx, 1'b0} +: 2];
    end

    // NOTE: every signal assigned here gets a default first so no latches are inferred.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        rails_d     = rails_q;
        gnt_d       = '0;
        tok_d       = tok_q;
        phase_d     = phase_q;
        timeout_hit = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found && !comp_s && sync_ready) begin
                    state_d = S_DATA;
                    idx_d   = win_idx;
                    ptr_d   = win_idx;
                    rails_d = 4'b0001 << win_val;
                end
            end
            S_DATA: begin
                if (comp_s) begin
                    state_d = S_NULL;
                    rails_d = 4'b0000;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
                end
            end
            S_NULL: begin
                if (!comp_s) begin
                    state_d = S_IDLE;
                    tok_d   = tok_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                rails_d = 4'b0000;
            end
        endcase

        // Phase counter saturates at TIMEOUT so err fires once per stuck phase.
        if (state_d != state_q) begin
            phase_d = '0;
        end else if (state_q != S_IDLE && phase_q != TMAX) begin
            phase_d     = phase_q + 16'd1;
            timeout_hit = (phase_q == TPRE);
        end

        err_d  = timeout_hit ? 1'b1 : (err_clr ? 1'b0 : err_q);
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_RST;
            idx_q   <= '0;
            rails_q <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            tok_q   <= '0;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            rails_q <= rails_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            tok_q   <= tok_d;
            phase_q <= phase_d;
        end
    end

    assign rails   = rails_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign tok_cnt = tok_q;

endmodule

// File: tb/tb_ncl4_inject_arbiter.sv
// Bench for ncl4_inject_arbiter: directed scenarios, a behavioural first pipeline stage,
// and a scoreboard monitor that checks every grant against queued expectations.
module tb_ncl4_inject_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              init_n;
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] req_val;
    logic              comp_in;
    logic [3:0]        rails;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              err;
    logic              err_clr;
    logic [15:0]       tok_cnt;

    logic comp_echo = 1'b0;
    logic comp_ovr_en;
    logic comp_ovr;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   gnt_seen = 0;
    int   g0;
    logic [3:0]      prev_rails = '0;
    logic [3:0]      last_rails = '0;
    logic [NREQ-1:0] prev_gnt = '0;

    ncl4_inject_arbiter #(.NREQ(NREQ), .SYNC_STAGES(2), .TIMEOUT(10)) dut (
        .clk     (clk),
        .init_n  (init_n),
        .req     (req),
        .req_val (req_val),
        .comp_in (comp_in),
        .rails   (rails),
        .gnt     (gnt),
        .busy    (busy),
        .err     (err),
        .err_clr (err_clr),
        .tok_cnt (tok_cnt)
    );

    always #5 clk = ~clk;

    // First pipeline stage: completion follows the rails 3 ns later.
    always @(rails) begin
        #3;
        comp_echo = |rails;
    end

    assign comp_in = comp_ovr_en ? comp_ovr : comp_echo;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (init_n) begin
            check("rails_onehot0", int'($onehot0(rails)), 1);
            if (prev_rails != 0 && rails != 0) check("rails_direct_change", int'(rails), int'(prev_rails));
            check("gnt_onehot0", int'($onehot0(gnt)), 1);
            if (prev_gnt != 0) check("gnt_width", int'(gnt), 0);
            if (gnt != 0) begin
                if (sb.size() == 0) begin
                    check("gnt_unexpected", int'(gnt), 0);
                end else begin
                    e = sb.pop_front();
                    check("gnt_idx", int'(gnt), 1 << e.idx);
                    check("gnt_rails", int'(last_rails), 1 << e.val);
                end
                gnt_seen++;
            end
            if (rails != 0) last_rails = rails;
            prev_rails = rails;
            prev_gnt   = gnt;
        end else begin
            prev_rails = '0;
            prev_gnt   = '0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnts(input int n);
        int start;
        int cyc;
        start = gnt_seen;
        cyc   = 0;
        while (gnt_seen < start + n && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("gnt_wait", gnt_seen - start, n);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("idle_wait", int'(busy), 0);
    endtask

    task automatic push(input int idx, input int val);
        exp_t x;
        x.idx = idx;
        x.val = val;
        sb.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        init_n      = 1'b0;
        req         = '0;
        req_val     = '0;
        err_clr     = 1'b0;
        comp_ovr_en = 1'b0;
        comp_ovr    = 1'b0;
        tick(2);
        check("rst_rails", int'(rails), 0);
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err), 0);
        check("rst_tok", int'(tok_cnt), 0);

        // Single requester
        init_n = 1'b1;
        tick(3);
        req          = 4'b0001;
        req_val[1:0] = 2'd2;
        push(0, 2);
        tick(1);
        check("single_rails", int'(rails), 4);
        check("single_busy", int'(busy), 1);
        wait_gnts(1);
        req = '0;
        wait_idle();
        check("single_tok", int'(tok_cnt), 1);
        check("single_err", int'(err), 0);

        // Round-robin, all four requesting
        init_n = 1'b0;
        tick(1);
        check("rst2_tok", int'(tok_cnt), 0);
        init_n = 1'b1;
        tick(3);
        req_val = 8'b01_11_00_10;
        req     = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            push(0, 2);
            push(1, 0);
            push(2, 3);
            push(3, 1);
        end
        wait_gnts(8);
        req = '0;
        wait_idle();
        check("rr_tok", int'(tok_cnt), 8);
        check("rr_err", int'(err), 0);

        // Stuck completion
        comp_ovr_en  = 1'b1;
        comp_ovr     = 1'b0;
        req          = 4'b0010;
        req_val[3:2] = 2'd1;
        push(1, 1);
        tick(1);
        check("stuck_rails", int'(rails), 2);
        tick(9);
        check("stuck_err_early", int'(err), 0);
        tick(1);
        check("stuck_err_set", int'(err), 1);
        tick(3);
        check("stuck_err_sticky", int'(err), 1);
        check("stuck_rails_hold", int'(rails), 2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("stuck_err_clr", int'(err), 0);
        comp_ovr_en = 1'b0;
        wait_gnts(1);
        req = '0;
        wait_idle();
        check("stuck_tok", int'(tok_cnt), 9);
        check("stuck_err_after", int'(err), 0);

        // Stale DATA at reset release
        init_n       = 1'b0;
        comp_ovr_en  = 1'b1;
        comp_ovr     = 1'b1;
        req          = 4'b0010;
        req_val[3:2] = 2'd3;
        tick(2);
        init_n = 1'b1;
        g0     = gnt_seen;
        tick(6);
        check("stale_rails", int'(rails), 0);
        check("stale_busy", int'(busy), 0);
        check("stale_nognt", gnt_seen - g0, 0);
        push(1, 3);
        comp_ovr_en = 1'b0;
        wait_gnts(1);
        req = '0;
        wait_idle();
        check("stale_tok", int'(tok_cnt), 1);

        // Reset in the middle of a DATA phase
        comp_ovr_en  = 1'b1;
        comp_ovr     = 1'b0;
        req          = 4'b0100;
        req_val[5:4] = 2'd0;
        tick(1);
        check("mid_rails", int'(rails), 1);
        tick(10);
        check("mid_err_pre", int'(err), 1);
        #3;
        init_n = 1'b0;
        #1;
        check("mid_rst_rails", int'(rails), 0);
        check("mid_rst_gnt", int'(gnt), 0);
        check("mid_rst_err", int'(err), 0);
        check("mid_rst_tok", int'(tok_cnt), 0);
        check("mid_rst_busy", int'(busy), 0);
        tick(2);
        req_val     = 8'b01_11_00_10;
        req         = 4'b1111;
        comp_ovr_en = 1'b0;
        push(0, 2);
        init_n = 1'b1;
        wait_gnts(1);
        req = '0;
        wait_idle();
        check("mid_tok", int'(tok_cnt), 1);

        // Requester drops req and changes req_val after latch
        req          = 4'b1000;
        req_val[7:6] = 2'd2;
        push(3, 2);
        tick(1);
        check("drop_rails", int'(rails), 4);
        req          = '0;
        req_val[7:6] = 2'd1;
        tick(1);
        check("drop_rails_hold", int'(rails), 4);
        wait_gnts(1);
        wait_idle();
        check("drop_tok", int'(tok_cnt), 2);

        tick(3);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
